// File: rtl/mem_map_pkg.sv
// mem_map_pkg: shared memory-map constants and address decode for the
// memory-bus target. I/O lives in the 64 KB window at 0x30000, which is
// selected by bus_a[17:16] == 2'b11. Every other value of that field is RAM.
package mem_map_pkg;

  localparam logic [17:0] IO_BASE = 18'h30000;
  localparam logic [17:0] IO_UART = 18'h00000;  // offset of the UART data byte
  localparam logic [17:0] IO_CNT  = 18'h00004;  // offset of the 4-byte counter snapshot
  localparam logic [1:0]  IO_SEL  = 2'b11;      // bus_a[17:16] value selecting I/O

  typedef enum logic [1:0] {
    SEL_RAM  = 2'b00,
    SEL_UART = 2'b01,
    SEL_CNT  = 2'b10,
    SEL_NONE = 2'b11
  } sel_e;

  // Classify an 18-bit bus address into RAM / UART / counter / unmapped I/O.
  function automatic sel_e decode_sel(input logic [17:0] a);
    sel_e s;
    if (a[17:16] != IO_SEL) begin
      s = SEL_RAM;
    end else if (a == (IO_BASE + IO_UART)) begin
      s = SEL_UART;
    end else if ({a[17:2], 2'b00} == (IO_BASE + IO_CNT)) begin
      s = SEL_CNT;
    end else begin
      s = SEL_NONE;
    end
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with synchronous active-high reset.
//   push_i/din_i : write request and data; accepted when not full, or when
//                  full but an effective pop happens in the same cycle
//   pop_i        : read request; ignored while empty
//   dout_o       : current head entry (valid when !empty_o)
//   full_o/empty_o/count_o : occupancy, all derived from registers
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_s, pop_s;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == {CW{1'b0}});
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // Effective handshakes and next pointer/occupancy values.
  always_comb begin
    pop_s    = pop_i & ~empty_o;
    push_s   = push_i & (~full_o | pop_s);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1'b1);
      2'b01:   count_d = count_q - CW'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy guards them.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/mem_bus_target.sv
// mem_bus_target: RAM plus memory-mapped I/O responder for the byte-wide
// CPU memory bus.
//   clk, rst          : clock, synchronous active-high reset
//   rdy               : global enable; low freezes all bus-side state
//   bus_a/bus_wr/bus_wdata : CPU request (address, direction, write byte)
//   bus_rdata         : read data, one cycle after the request
//   io_buffer_full    : TX FIFO within two entries of full
//   tx_valid/tx_data/tx_ready : outgoing UART byte stream
//   rx_valid/rx_data/rx_ready : incoming UART byte stream
//   sim_done          : sticky, set by a write to 0x30004
//   tx_overflow       : sticky, set when a TX byte is dropped
module mem_bus_target
  import mem_map_pkg::*;
#(
  parameter int RAM_ADDR_W = 17,
  parameter int TX_DEPTH   = 16,
  parameter int RX_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] bus_a,
  input  logic        bus_wr,
  input  logic [7:0]  bus_wdata,
  output logic [7:0]  bus_rdata,
  output logic        io_buffer_full,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        sim_done,
  output logic        tx_overflow
);

  localparam int TX_CW = $clog2(TX_DEPTH) + 1;
  localparam int RX_CW = $clog2(RX_DEPTH) + 1;

  logic [7:0]            ram_q [2**RAM_ADDR_W];
  logic [7:0]            ram_rd_q;
  logic [RAM_ADDR_W-1:0] ram_idx_s;
  logic                  ram_wr_s, ram_rd_s;

  sel_e                  sel_s;
  logic [17:0]           a18_s;
  logic                  unused_bus_a_s;

  logic [7:0]            io_rdata_q, io_rdata_d;
  logic                  src_ram_q, src_ram_d;  // which register drives bus_rdata
  logic [31:0]           cnt_q, cnt_d;
  logic [31:0]           snap_q, snap_d;
  logic                  run_q, run_d;          // previous rdy cycle was a UART read
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;

  logic                  tx_push_s, tx_full_s, tx_empty_s, tx_pop_eff_s;
  logic [7:0]            tx_din_s;
  logic [TX_CW-1:0]      tx_count_s;
  logic                  rx_push_s, rx_pop_s, rx_full_s, rx_empty_s;
  logic [7:0]            rx_dout_s;
  logic [RX_CW-1:0]      rx_count_unused_s;

  assign a18_s          = bus_a[17:0];
  assign unused_bus_a_s = ^bus_a[31:18];
  assign ram_idx_s      = bus_a[RAM_ADDR_W-1:0];
  assign sel_s          = decode_sel(a18_s);

  // Bus-side strobes: RAM access, TX push (data byte or stop marker), RX pop.
  always_comb begin
    ram_wr_s  = 1'b0;
    ram_rd_s  = 1'b0;
    tx_push_s = 1'b0;
    tx_din_s  = 8'h00;
    rx_pop_s  = 1'b0;
    if (rdy && !rst) begin
      case (sel_s)
        SEL_RAM: begin
          ram_wr_s = bus_wr;
          ram_rd_s = ~bus_wr;
        end
        SEL_UART: begin
          // A zero data byte is swallowed; 0x00 on the stream means "stop".
          tx_push_s = bus_wr & (bus_wdata != 8'h00);
          tx_din_s  = bus_wdata;
          rx_pop_s  = ~bus_wr & ~run_q;
        end
        SEL_CNT: begin
          tx_push_s = bus_wr & (a18_s[1:0] == 2'b00);
          tx_din_s  = 8'h00;
        end
        default: begin
          tx_push_s = 1'b0;
        end
      endcase
    end else begin
      ram_wr_s = 1'b0;
    end
  end

  // RAM write port and registered read port; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_wr_s) begin
      ram_q[ram_idx_s] <= bus_wdata;
    end
    if (ram_rd_s) begin
      ram_rd_q <= ram_q[ram_idx_s];
    end
  end

  assign tx_pop_eff_s = tx_ready & ~tx_empty_s;
  assign rx_push_s    = rx_valid & rx_ready;

  // Next state for I/O read data, counter/snapshot, read-run flag and sticky flags.
  always_comb begin
    io_rdata_d = io_rdata_q;
    src_ram_d  = src_ram_q;
    cnt_d      = cnt_q;
    snap_d     = snap_q;
    run_d      = run_q;
    done_d     = done_q;
    // A push into a full FIFO survives only if a pop frees a slot this cycle.
    ovf_d      = ovf_q | (tx_push_s & tx_full_s & ~tx_pop_eff_s);
    if (rdy) begin
      cnt_d = cnt_q + 32'd1;
      run_d = ~bus_wr & (sel_s == SEL_UART);
      if (bus_wr) begin
        done_d = done_q | ((sel_s == SEL_CNT) && (a18_s[1:0] == 2'b00));
      end else begin
        src_ram_d = (sel_s == SEL_RAM);
        case (sel_s)
          SEL_UART: begin
            // Re-reads inside a run keep the byte popped on the first cycle.
            if (!run_q) begin
              io_rdata_d = rx_empty_s ? 8'h00 : rx_dout_s;
            end else begin
              io_rdata_d = io_rdata_q;
            end
          end
          SEL_CNT: begin
            case (a18_s[1:0])
              2'b00: begin
                snap_d     = cnt_q;
                io_rdata_d = cnt_q[7:0];
              end
              2'b01:   io_rdata_d = snap_q[15:8];
              2'b10:   io_rdata_d = snap_q[23:16];
              default: io_rdata_d = snap_q[31:24];
            endcase
          end
          SEL_NONE: io_rdata_d = 8'h00;
          default:  io_rdata_d = io_rdata_q;
        endcase
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Bus-side state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      io_rdata_q <= 8'h00;
      src_ram_q  <= 1'b0;
      cnt_q      <= 32'h0000_0000;
      snap_q     <= 32'h0000_0000;
      run_q      <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      io_rdata_q <= io_rdata_d;
      src_ram_q  <= src_ram_d;
      cnt_q      <= cnt_d;
      snap_q     <= snap_d;
      run_q      <= run_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus_rdata      = src_ram_q ? ram_rd_q : io_rdata_q;
  assign sim_done       = done_q;
  assign tx_overflow    = ovf_q;
  assign io_buffer_full = (tx_count_s >= TX_CW'(TX_DEPTH - 2));
  assign tx_valid       = ~tx_empty_s;
  assign rx_ready       = ~rx_full_s;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_push_s),
    .din_i   (tx_din_s),
    .pop_i   (tx_ready),
    .dout_o  (tx_data),
    .full_o  (tx_full_s),
    .empty_o (tx_empty_s),
    .count_o (tx_count_s)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rx_push_s),
    .din_i   (rx_data),
    .pop_i   (rx_pop_s),
    .dout_o  (rx_dout_s),
    .full_o  (rx_full_s),
    .empty_o (rx_empty_s),
    .count_o (rx_count_unused_s)
  );

endmodule
